// File: rtl/hit_generator.sv
// Programmable hit pulse train generator for TDC front-end calibration.
// Three-state FSM (IDLE/HIGH/LOW) with latched burst configuration and registered outputs.
module hit_generator (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        enable,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [15:0] iHighCnt,
  input  logic [15:0] iLowCnt,
  input  logic [15:0] iNumPulses,
  output logic        oHit,
  output logic        oRiseStrobe,
  output logic        oFallStrobe,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oPulseCount
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic [15:0] high_len_q, high_len_d;
  logic [15:0] low_len_q, low_len_d;
  logic [15:0] num_q, num_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pcount_q, pcount_d;
  logic        stop_pend_q, stop_pend_d;
  logic        hit_q, hit_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // State and datapath registers; enable=0 freezes everything except the strobes,
  // which fall to 0 because the output logic sees no state transition.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= IDLE;
      high_len_q  <= '0;
      low_len_q   <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      pcount_q    <= '0;
      stop_pend_q <= 1'b0;
      hit_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      pcount_q    <= pcount_d;
      stop_pend_q <= stop_pend_d;
      hit_q       <= hit_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    pcount_d    = pcount_q;
    stop_pend_d = stop_pend_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (iStart && !iStop) begin
            state_d     = HIGH;
            high_len_d  = (iHighCnt == 16'd0) ? 16'd1 : iHighCnt;
            low_len_d   = (iLowCnt == 16'd0) ? 16'd1 : iLowCnt;
            num_d       = iNumPulses;
            pcount_d    = '0;
            cnt_d       = 16'd1;
            stop_pend_d = 1'b0;
          end
        end
        HIGH: begin
          // A stop seen mid-phase is remembered so the pulse is never truncated.
          if (cnt_q >= high_len_q) begin
            pcount_d    = pcount_q + 16'd1;
            cnt_d       = 16'd1;
            state_d     = (iStop || stop_pend_q) ? IDLE : LOW;
            stop_pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (iStop) stop_pend_d = 1'b1;
          end
        end
        LOW: begin
          if (iStop) begin
            state_d = IDLE;
          end else if (cnt_q >= low_len_q) begin
            cnt_d   = 16'd1;
            state_d = ((num_q != 16'd0) && (pcount_q == num_q)) ? IDLE : HIGH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are precomputed from the next state so the registered outputs line up with it.
  always_comb begin
    hit_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    rise_d = enable && (state_d == HIGH) && (state_q != HIGH);
    fall_d = enable && (state_q == HIGH) && (state_d != HIGH);
    done_d = enable && (state_q != IDLE) && (state_d == IDLE);
  end

  assign oHit        = hit_q;
  assign oRiseStrobe = rise_q;
  assign oFallStrobe = fall_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oPulseCount = pcount_q;

endmodule

// File: tb/tb_hit_generator.sv
// Directed self-checking bench for hit_generator: bursts, zero lengths, stop, stall, reset, collisions.
module tb_hit_generator;

  logic        iClk = 1'b0;
  logic        iRst, enable, iStart, iStop;
  logic [15:0] iHighCnt, iLowCnt, iNumPulses;
  logic        oHit, oRiseStrobe, oFallStrobe, oBusy, oDone;
  logic [15:0] oPulseCount;

  int n_checks = 0;
  int n_fail   = 0;

  hit_generator dut (
    .iClk(iClk), .iRst(iRst), .enable(enable), .iStart(iStart), .iStop(iStop),
    .iHighCnt(iHighCnt), .iLowCnt(iLowCnt), .iNumPulses(iNumPulses),
    .oHit(oHit), .oRiseStrobe(oRiseStrobe), .oFallStrobe(oFallStrobe),
    .oBusy(oBusy), .oDone(oDone), .oPulseCount(oPulseCount)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Observed flags packed as {hit, rise, fall, busy, done}.
  function automatic logic [4:0] flags();
    return {oHit, oRiseStrobe, oFallStrobe, oBusy, oDone};
  endfunction

  task automatic launch(input logic [15:0] h, input logic [15:0] l, input logic [15:0] n);
    iHighCnt = h; iLowCnt = l; iNumPulses = n;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  initial begin
    logic [4:0] e;
    iRst = 1'b0; enable = 1'b1; iStart = 1'b0; iStop = 1'b0;
    iHighCnt = '0; iLowCnt = '0; iNumPulses = '0;
    #1;
    check_eq("reset_flags", {27'd0, flags()}, 32'd0);
    check_eq("reset_count", {16'd0, oPulseCount}, 32'd0);
    #20;
    iRst = 1'b1;
    tick();
    tick();
    check_eq("idle_after_reset", {27'd0, flags()}, 32'd0);
    $display("test reset: done");

    // Basic burst H=3 L=2 N=2
    launch(16'd3, 16'd2, 16'd2);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      e = {(c inside {[1:3], [6:8]}), (c == 1 || c == 6), (c == 4 || c == 9), (c <= 10), (c == 11)};
      check_eq($sformatf("basic_c%0d", c), {27'd0, flags()}, {27'd0, e});
    end
    check_eq("basic_count", {16'd0, oPulseCount}, 32'd2);
    $display("test basic burst: done");

    // Zero lengths H=0 L=0 N=3
    launch(16'd0, 16'd0, 16'd3);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      e = {(c <= 6 && c % 2 == 1), (c <= 5 && c % 2 == 1), (c <= 6 && c % 2 == 0), (c <= 6), (c == 7)};
      check_eq($sformatf("zero_c%0d", c), {27'd0, flags()}, {27'd0, e});
    end
    check_eq("zero_count", {16'd0, oPulseCount}, 32'd3);
    $display("test zero lengths: done");

    // Continuous burst, stop in 2nd high cycle of pulse 5
    launch(16'd4, 16'd4, 16'd0);
    for (int c = 1; c <= 38; c++) begin
      int ph;
      if (c > 1) tick();
      iStop = (c == 34);
      ph = (c - 1) % 8;
      e = {(c <= 36 && ph < 4), (c <= 36 && ph == 0), (c <= 37 && ph == 4), (c <= 36), (c == 37)};
      check_eq($sformatf("cont_c%0d", c), {27'd0, flags()}, {27'd0, e});
      if (c <= 37) check_eq($sformatf("cont_cnt_c%0d", c), {16'd0, oPulseCount}, (c - 1) / 8 + ((ph >= 4) ? 1 : 0));
    end
    iStop = 1'b0;
    $display("test continuous stop in HIGH: done");

    // Stop during LOW: immediate return to IDLE
    launch(16'd2, 16'd5, 16'd0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      iStop = (c == 4);
      e = {(c <= 2), (c == 1), (c == 3), (c <= 4), (c == 5)};
      check_eq($sformatf("lowstop_c%0d", c), {27'd0, flags()}, {27'd0, e});
    end
    iStop = 1'b0;
    check_eq("lowstop_count", {16'd0, oPulseCount}, 32'd1);
    $display("test stop in LOW: done");

    // Enable stall: high phase stretched by four disabled cycles
    launch(16'd3, 16'd1, 16'd1);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      enable = !(c >= 2 && c <= 5);
      e = {(c <= 7), (c == 1), (c == 8), (c <= 8), (c == 9)};
      check_eq($sformatf("stall_c%0d", c), {27'd0, flags()}, {27'd0, e});
    end
    enable = 1'b1;
    check_eq("stall_count", {16'd0, oPulseCount}, 32'd1);
    $display("test enable stall: done");

    // Asynchronous reset in the second pulse's HIGH phase
    launch(16'd2, 16'd1, 16'd0);
    tick(); tick(); tick();
    check_eq("rst_pre_hit", {31'd0, oHit}, 32'd1);
    check_eq("rst_pre_count", {16'd0, oPulseCount}, 32'd1);
    #2 iRst = 1'b0;
    #1;
    check_eq("rst_async_flags", {27'd0, flags()}, 32'd0);
    check_eq("rst_async_count", {16'd0, oPulseCount}, 32'd0);
    tick();
    iRst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("rst_post_c%0d", c), {27'd0, flags()}, 32'd0);
    end
    $display("test reset mid-burst: done");

    // iStart during LOW with altered config is ignored
    launch(16'd2, 16'd3, 16'd2);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      iStart = (c >= 3 && c <= 5);
      iHighCnt = (c >= 3 && c <= 5) ? 16'd9 : 16'd2;
      e = {(c inside {[1:2], [6:7]}), (c == 1 || c == 6), (c == 3 || c == 8), (c <= 10), (c == 11)};
      check_eq($sformatf("coll_c%0d", c), {27'd0, flags()}, {27'd0, e});
    end
    iStart = 1'b0;
    check_eq("coll_count", {16'd0, oPulseCount}, 32'd2);

    // iStart with iStop in IDLE: stop wins
    iStart = 1'b1; iStop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("startstop_c%0d", c), {27'd0, flags()}, 32'd0);
    end
    iStart = 1'b0; iStop = 1'b0;
    $display("test start collisions: done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_generator.md
HIT_GENERATOR -- requirements
Module: hit_generator

Programmable test-hit pulse train generator. It drives the hit input of the TDC edge-detection front end for calibration and self-test.

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 iClk  in  1  sole clock; all state updates on its rising edge.
REQ-003 iRst  in  1  reset; asynchronous, active-low; 0 = reset asserted.
REQ-004 enable  in  1  clock enable; 0 freezes all state and outputs.
REQ-005 iStart  in  1  level, sampled per enabled cycle; starts a burst.
REQ-006 iStop  in  1  level, sampled per enabled cycle; ends a burst early.
REQ-007 iHighCnt  in  16  high-phase length in cycles; 0 is treated as 1.
REQ-008 iLowCnt  in  16  low-phase length in cycles; 0 is treated as 1.
REQ-009 iNumPulses  in  16  pulses per burst; 0 = continuous until stopped.
REQ-010 oHit  out  1  registered hit waveform.
REQ-011 oRiseStrobe  out  1  one-cycle flag: first cycle of each high phase.
REQ-012 oFallStrobe  out  1  one-cycle flag: first cycle oHit is 0 after a high phase.
REQ-013 oBusy  out  1  1 while the state is HIGH or LOW.
REQ-014 oDone  out  1  one-cycle flag on return to IDLE after a burst.
REQ-015 oPulseCount  out  16  falling edges produced in the current or last burst.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-017 In IDLE, an enabled cycle with iStart=1 and iStop=0 SHALL latch iHighCnt, iLowCnt and iNumPulses, clear oPulseCount, and enter HIGH on the next cycle.
REQ-018 Latched configuration SHALL be used for the whole burst; input changes during a burst SHALL be ignored.
REQ-019 HIGH SHALL last max(iHighCnt,1) enabled cycles with oHit=1; oRiseStrobe SHALL be 1 in its first cycle only.
REQ-020 At the end of HIGH, oPulseCount SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-021 After HIGH, the FSM SHALL enter LOW unless the burst terminates (REQ-024 to REQ-026); oFallStrobe SHALL be 1 in the first cycle after HIGH, in either LOW or IDLE.
REQ-022 LOW SHALL last max(iLowCnt,1) enabled cycles with oHit=0.
REQ-023 After LOW, the FSM SHALL enter HIGH if more pulses remain, else IDLE.
REQ-024 With iNumPulses=N>0, the burst SHALL be N pulses; after the Nth LOW phase, the FSM SHALL enter IDLE.
REQ-025 With iNumPulses=0, the burst SHALL continue until iStop; the 16-bit count wraps freely.
REQ-026 iStop sampled in HIGH SHALL let the current high phase complete (no runt pulse) and then enter IDLE, skipping LOW.
REQ-027 iStop sampled in LOW SHALL enter IDLE on the next cycle.
REQ-028 oDone SHALL be 1 for exactly the first IDLE cycle after any burst, whether completed or stopped.
REQ-029 iStart while the state is HIGH or LOW SHALL be ignored.
REQ-030 iStart and iStop together in IDLE: stop SHALL win; the FSM stays IDLE and oDone stays 0.
REQ-031 With enable=0, state, counters, oHit and oPulseCount SHALL hold, and oRiseStrobe, oFallStrobe and oDone SHALL hold 0.
REQ-032 A frozen phase SHALL be lengthened by the number of disabled cycles.
REQ-033 All outputs SHALL be driven from registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-034 iRst=0 SHALL immediately force state IDLE, oHit=0, oRiseStrobe=0, oFallStrobe=0, oBusy=0, oDone=0, oPulseCount=0 and clear the latched configuration, independent of iClk.
REQ-035 Reset asserted mid-burst SHALL abort the burst without an oDone pulse.
REQ-036 After reset release, the FSM SHALL stay IDLE until a valid iStart.

Verification
REQ-037 Basic burst: High=3, Low=2, Num=2, iStart in cycle 0 -> oHit=1 in cycles 1-3 and 6-8, 0 in 4-5 and 9-10; rise strobes at 1 and 6; fall strobes at 4 and 9; oBusy in 1-10; oDone at 11; oPulseCount=2.
REQ-038 Zero lengths: High=0, Low=0, Num=3 -> oHit sequence 1,0,1,0,1,0 in cycles 1-6; oDone at 7; oPulseCount=3.
REQ-039 Continuous stop: Num=0, High=4, Low=4, iStop in the 2nd HIGH cycle of pulse 5 -> high phase completes (4 cycles), oFallStrobe and oDone in the same cycle, IDLE, oPulseCount=5.
REQ-040 Enable stall: High=3, enable=0 for 4 cycles starting in the 2nd HIGH cycle -> oHit high for 7 cycles total; no strobe during the stall.
REQ-041 Reset mid-burst: iRst=0 asynchronously during HIGH -> oHit=0 before the next clock edge, all outputs 0, no oDone after release.
REQ-042 Start collisions: iStart re-asserted during LOW -> ignored, burst unchanged; iStart and iStop together in IDLE -> stays IDLE, oDone=0.
